ahbgpio_cmd_master: RTL and testbench

Single-outstanding-pipeline AHB-Lite master that turns a simple valid/ready command stream into AHB-Lite NONSEQ transfers for the AHBGPIO slave, and returns write acknowledgements and read data on a response port. It sits directly upstream of AHBGPIO: it drives HADDR/HTRANS/HWRITE/HWDATA/HSEL and consumes HREADYOUT/HRDATA. A 4-entry command FIFO decouples the command source from bus wait states.

---
 rtl/ahbgpio_cmd_master.sv | 231 +++++++++++++++++++++++
 tb/tb_ahbgpio_cmd_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbgpio_cmd_master.sv
// ahbgpio_cmd_master
// AHB-Lite master that converts a valid/ready command stream into single
// NONSEQ word transfers for the AHBGPIO slave. It returns one response pulse
// per completed transfer. A small command FIFO decouples the command source
// from slave wait states. The address and data phases are tracked as a
// four-state pipeline {A, D}.
//
// Optional feature: define AHBGPIO_CMD_PARITY_EN to add the PARITYSEL input.
// With the feature enabled, write data bit 16 is replaced by the parity of
// bits [15:0] XOR PARITYSEL, computed when the command is pushed.

module ahbgpio_cmd_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response stream (no back-pressure)
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    // AHB-Lite master side
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic              HSEL,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
`ifdef AHBGPIO_CMD_PARITY_EN
    ,
    input  logic              PARITYSEL
`endif
);

    localparam int              PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [1:0]      TRANS_IDLE   = 2'b00;
    localparam logic [1:0]      TRANS_NONSEQ = 2'b10;

    // One queued command as it will appear on the bus.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    // Encoding is {A, D}: bit 1 = address phase on bus, bit 0 = data phase.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_DATA      = 2'b01,
        ST_ADDR      = 2'b10,
        ST_ADDR_DATA = 2'b11
    } pipe_state_t;

    // ------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               push;
    entry_t             push_entry;
    logic [DATA_W-1:0]  push_wdata;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    pipe_state_t        state;
    pipe_state_t        state_next;
    logic               pop;
    logic               complete;
    logic               a_active;
    logic               d_active;

    // Address-phase write data waits here until the data phase begins.
    logic [DATA_W-1:0]  a_wdata;
    // Direction of the transfer currently in its data phase.
    logic               d_write;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // The FIFO refuses commands while reset is applied so nothing can slip
    // in during the reset cycle.
    assign cmd_ready = !HRESET && !full;
    assign push      = cmd_valid && cmd_ready;

    assign a_active = (state == ST_ADDR) || (state == ST_ADDR_DATA);
    assign d_active = (state == ST_DATA) || (state == ST_ADDR_DATA);

    // Bus control is a direct decode of the address-phase flag.
    assign HTRANS = a_active ? TRANS_NONSEQ : TRANS_IDLE;
    assign HSEL   = a_active;
    assign HSIZE  = 3'b010;
    assign busy   = !empty || a_active || d_active;

    // Shape the write data at push time. Parity uses the raw low half-word.
    always_comb begin
        push_wdata = cmd_wdata;
`ifdef AHBGPIO_CMD_PARITY_EN
        if (cmd_write) begin
            push_wdata[16] = (^cmd_wdata[15:0]) ^ PARITYSEL;
        end
`endif
        push_entry.write = cmd_write;
        push_entry.addr  = cmd_addr;
        push_entry.wdata = push_wdata;
    end

    // Write accepted commands into FIFO storage.
    // NOTE: storage carries no reset; validity comes only from count/pointers, which are reset.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Advance FIFO pointers and occupancy. Power-of-two depth lets pointers wrap naturally.
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pipeline state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, pop and completion decode. Nothing moves while the slave stalls.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        complete   = 1'b0;
        if (HREADYOUT) begin
            pop = !empty;
            case (state)
                ST_IDLE: begin
                    state_next = pop ? ST_ADDR : ST_IDLE;
                end
                ST_ADDR: begin
                    state_next = pop ? ST_ADDR_DATA : ST_DATA;
                end
                ST_ADDR_DATA: begin
                    complete   = 1'b1;
                    state_next = pop ? ST_ADDR_DATA : ST_DATA;
                end
                ST_DATA: begin
                    complete   = 1'b1;
                    state_next = pop ? ST_ADDR : ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Address-phase registers load on pop and otherwise hold, which also holds them on an idle bus.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            a_wdata <= '0;
        end else if (pop) begin
            HADDR   <= mem[rd_ptr].addr;
            HWRITE  <= mem[rd_ptr].write;
            a_wdata <= mem[rd_ptr].wdata;
        end
    end

    // Data-phase registers take over the address-phase transfer when the slave is ready.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HWDATA  <= '0;
            d_write <= 1'b0;
        end else if (HREADYOUT && a_active) begin
            HWDATA  <= a_wdata;
            d_write <= HWRITE;
        end
    end

    // Response pulse on completion; direction and read data hold until the next one.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete;
            if (complete) begin
                rsp_write <= d_write;
                rsp_rdata <= d_write ? '0 : HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahbgpio_cmd_master.sv
// Testbench for ahbgpio_cmd_master.
// Directed stimulus pushes expected responses, with the cycle on which each
// must appear, into a queue. A monitor on the falling edge pops and compares
// every response pulse. Bus-side signals are checked inline.

module tb_ahbgpio_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
`ifdef AHBGPIO_CMD_PARITY_EN
    logic        PARITYSEL;
`endif

    ahbgpio_cmd_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .FIFO_DEPTH(4)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HSEL     (HSEL),
        .HWDATA   (HWDATA),
        .HREADYOUT(HREADYOUT),
        .HRDATA   (HRDATA)
`ifdef AHBGPIO_CMD_PARITY_EN
        ,
        .PARITYSEL(PARITYSEL)
`endif
    );

    always #5 HCLK = ~HCLK;

    // Rising-edge counter: during the cycle after edge n, cyc == n.
    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic expect_rsp(input logic w, input logic [31:0] rdata, input int at);
        exp_q.push_back('{w: w, rdata: rdata, at: at});
    endtask

    // Present a command for one edge. The FIFO must be ready beforehand.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        check("push_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Response monitor: every pulse must match the oldest expectation and its cycle.
    always @(negedge HCLK) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: response due at cycle %0d not seen by cycle %0d",
                     exp_q[0].at, cyc);
            void'(exp_q.pop_front());
        end
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got write=%b rdata=%h at cycle %0d, expected none",
                         rsp_write, rsp_rdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_write !== mon_e.w || rsp_rdata !== mon_e.rdata || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL rsp_compare: got write=%b rdata=%h cycle=%0d expected write=%b rdata=%h cycle=%0d",
                             rsp_write, rsp_rdata, cyc, mon_e.w, mon_e.rdata, mon_e.at);
                end
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p;
    int q;

    initial begin
        HRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0000_1234;
`ifdef AHBGPIO_CMD_PARITY_EN
        PARITYSEL = 1'b0;
`endif

        // ---- reset state ----
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_htrans",    32'(HTRANS),    32'd0);
        check("rst_hsel",      32'(HSEL),      32'd0);
        check("rst_hsize",     32'(HSIZE),     32'd2);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_haddr",     HADDR,          32'd0);
        check("rst_hwdata",    HWDATA,         32'd0);
        HRESET = 1'b0;
        tick();
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---- single write: NONSEQ +1, data +2, response +3 ----
        push(1'b1, 32'h0000_0000, 32'h0000_00A5);
        p = cyc;
        expect_rsp(1'b1, 32'h0, p + 3);
        check("w1_busy", 32'(busy), 32'd1);
        tick();
        check("w1_htrans", 32'(HTRANS), 32'd2);
        check("w1_hsel",   32'(HSEL),   32'd1);
        check("w1_haddr",  HADDR,       32'h0);
        check("w1_hwrite", 32'(HWRITE), 32'd1);
        tick();
        check("w1_idle",   32'(HTRANS), 32'd0);
        check("w1_hsel0",  32'(HSEL),   32'd0);
        check("w1_hwdata", HWDATA,      32'h0000_00A5);
        repeat (3) tick();
        check("w1_done_busy", 32'(busy), 32'd0);

        // ---- write then read back-to-back ----
        push(1'b1, 32'h0000_0004, 32'h0000_0001);
        p = cyc;
        push(1'b0, 32'h0000_0000, 32'h0000_0000);
        expect_rsp(1'b1, 32'h0, p + 3);
        expect_rsp(1'b0, 32'h0000_1234, p + 4);
        check("wr_a1_htrans", 32'(HTRANS), 32'd2);
        check("wr_a1_haddr",  HADDR,       32'h4);
        check("wr_a1_hwrite", 32'(HWRITE), 32'd1);
        tick();
        check("wr_a2_htrans", 32'(HTRANS), 32'd2);
        check("wr_a2_haddr",  HADDR,       32'h0);
        check("wr_a2_hwrite", 32'(HWRITE), 32'd0);
        check("wr_d1_hwdata", HWDATA,      32'h1);
        repeat (4) tick();

        // ---- FIFO full with bus stalled, fifth accepted after first pop ----
        HRDATA    = 32'hCAFE_0001;
        HREADYOUT = 1'b0;
        push(1'b1, 32'h0000_0010, 32'h0000_0011);
        push(1'b0, 32'h0000_0014, 32'h0000_0000);
        push(1'b1, 32'h0000_0018, 32'h0000_0033);
        push(1'b0, 32'h0000_001C, 32'h0000_0000);
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_busy",  32'(busy),      32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0020;
        cmd_wdata = 32'h0000_0055;
        repeat (2) tick();
        check("full_hold_ready",  32'(cmd_ready), 32'd0);
        check("full_hold_htrans", 32'(HTRANS),    32'd0);
        HREADYOUT = 1'b1;
        q = cyc + 1;
        expect_rsp(1'b1, 32'h0,         q + 2);
        expect_rsp(1'b0, 32'hCAFE_0001, q + 3);
        expect_rsp(1'b1, 32'h0,         q + 4);
        expect_rsp(1'b0, 32'hCAFE_0001, q + 5);
        expect_rsp(1'b1, 32'h0,         q + 6);
        tick();
        check("pop1_ready", 32'(cmd_ready), 32'd1);
        check("pop1_haddr", HADDR,          32'h10);
        tick();
        cmd_valid = 1'b0;
        check("pop2_haddr", HADDR, 32'h14);
        for (int k = 2; k < 5; k++) begin
            tick();
            check("stream_htrans", 32'(HTRANS), 32'd2);
            check("stream_haddr",  HADDR,       32'h10 + 32'(4 * k));
        end
        tick();
        check("stream_end_idle",  32'(HTRANS), 32'd0);
        check("stream_end_haddr", HADDR,       32'h20);
        repeat (4) tick();

        // ---- three-cycle stall during ADDR_DATA ----
        push(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        p = cyc;
        push(1'b1, 32'h0000_0044, 32'h0BAD_F00D);
        expect_rsp(1'b1, 32'h0, p + 6);
        expect_rsp(1'b1, 32'h0, p + 7);
        tick();
        check("ad_htrans", 32'(HTRANS), 32'd2);
        check("ad_haddr",  HADDR,       32'h44);
        check("ad_hwdata", HWDATA,      32'hDEAD_BEEF);
        HREADYOUT = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_htrans", 32'(HTRANS), 32'd2);
            check("stall_haddr",  HADDR,       32'h44);
            check("stall_hwdata", HWDATA,      32'hDEAD_BEEF);
        end
        HREADYOUT = 1'b1;
        tick();
        check("unstall_hwdata", HWDATA,      32'h0BAD_F00D);
        check("unstall_htrans", 32'(HTRANS), 32'd0);
        repeat (4) tick();

        // ---- reset with one transfer in data phase and three queued ----
        push(1'b1, 32'h0000_0080, 32'h0000_0001);
        tick();
        push(1'b1, 32'h0000_0084, 32'h0000_0002);
        HREADYOUT = 1'b0;
        push(1'b0, 32'h0000_0088, 32'h0000_0000);
        push(1'b1, 32'h0000_008C, 32'h0000_0004);
        check("pre_rst_htrans", 32'(HTRANS), 32'd0);
        check("pre_rst_busy",   32'(busy),   32'd1);
        HRESET = 1'b1;
        tick();
        check("mid_rst_htrans", 32'(HTRANS),    32'd0);
        check("mid_rst_busy",   32'(busy),      32'd0);
        check("mid_rst_rsp",    32'(rsp_valid), 32'd0);
        check("mid_rst_ready",  32'(cmd_ready), 32'd0);
        HRESET    = 1'b0;
        HREADYOUT = 1'b1;
        repeat (5) tick();
        check("post_rst_busy",   32'(busy),      32'd0);
        check("post_rst_htrans", 32'(HTRANS),    32'd0);
        check("post_rst_ready",  32'(cmd_ready), 32'd1);

        // ---- write-data shaping ----
`ifdef AHBGPIO_CMD_PARITY_EN
        PARITYSEL = 1'b0;
        push(1'b1, 32'h0000_0000, 32'h0000_0007);
        expect_rsp(1'b1, 32'h0, cyc + 3);
        repeat (2) tick();
        check("par_even_hwdata", HWDATA, 32'h0001_0007);
        repeat (2) tick();
        PARITYSEL = 1'b1;
        push(1'b1, 32'h0000_0000, 32'h0000_0007);
        expect_rsp(1'b1, 32'h0, cyc + 3);
        PARITYSEL = 1'b0;
        repeat (2) tick();
        check("par_odd_hwdata", HWDATA, 32'h0000_0007);
        repeat (2) tick();
        push(1'b1, 32'h0000_0000, 32'h0001_0000);
        expect_rsp(1'b1, 32'h0, cyc + 3);
        repeat (2) tick();
        check("par_clear_hwdata", HWDATA, 32'h0000_0000);
`else
        push(1'b1, 32'h0000_0000, 32'h0000_0007);
        expect_rsp(1'b1, 32'h0, cyc + 3);
        repeat (2) tick();
        check("raw_hwdata_a", HWDATA, 32'h0000_0007);
        repeat (2) tick();
        push(1'b1, 32'h0000_0000, 32'h0001_0000);
        expect_rsp(1'b1, 32'h0, cyc + 3);
        repeat (2) tick();
        check("raw_hwdata_b", HWDATA, 32'h0001_0000);
`endif

        // ---- drain, bounded ----
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            tick();
        end
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
